conv_job_sched: RTL and testbench

Job scheduler and address relocator for the `conv2d` engine. The scheduler accepts frame jobs (source and destination base addresses) from the host into a small queue. It runs them on the engine one at a time: it resets the engine, pulses `start`, waits for `ready`, and relocates the engine's frame-relative read and write addresses onto the shared 17-bit image memory. A per-job watchdog guarantees forward progress. Each job is reported with its id and an error flag. The block sits between the host/DMA job interface and the `conv2d` instance.

---
 rtl/conv_job_sched_if.sv | 41 ++++
 rtl/conv_job_sched.sv | 148 ++++++++++++++
 tb/tb_conv_job_sched.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_job_sched_if.sv
// Job, engine and memory-address signals between conv_job_sched and its neighbours.
// Suffixes are from the scheduler's point of view: _i flows into it, _o flows out of it.
interface conv_job_sched_if #(
   parameter int ADDR_W = 17,
   parameter int CNT_W  = 3
);
   logic              job_valid_i;
   logic              job_ready_o;
   logic [ADDR_W-1:0] job_src_i;
   logic [ADDR_W-1:0] job_dst_i;
   logic              eng_rst_o;
   logic              eng_start_o;
   logic              eng_ready_i;
   logic [ADDR_W-1:0] eng_addr_rd_i;
   logic [ADDR_W-1:0] eng_addr_wr_i;
   logic [ADDR_W-1:0] mem_addr_rd_o;
   logic [ADDR_W-1:0] mem_addr_wr_o;
   logic              done_valid_o;
   logic [7:0]        done_id_o;
   logic              done_err_o;
   logic              busy_o;
   logic [CNT_W-1:0]  pending_o;

   // Host/engine side.
   modport master (
      output job_valid_i, job_src_i, job_dst_i,
      output eng_ready_i, eng_addr_rd_i, eng_addr_wr_i,
      input  job_ready_o, eng_rst_o, eng_start_o,
      input  mem_addr_rd_o, mem_addr_wr_o,
      input  done_valid_o, done_id_o, done_err_o, busy_o, pending_o
   );

   // Scheduler side.
   modport slave (
      input  job_valid_i, job_src_i, job_dst_i,
      input  eng_ready_i, eng_addr_rd_i, eng_addr_wr_i,
      output job_ready_o, eng_rst_o, eng_start_o,
      output mem_addr_rd_o, mem_addr_wr_o,
      output done_valid_o, done_id_o, done_err_o, busy_o, pending_o
   );
endinterface

// File: rtl/conv_job_sched.sv
// Queues frame jobs for the conv2d engine, sequences reset/start/run for each one,
// relocates the engine's frame-relative addresses and aborts jobs that overrun a watchdog.
module conv_job_sched #(
   parameter int ADDR_W  = 17,
   parameter int QDEPTH  = 4,
   parameter int CNT_W   = 3,
   parameter int TIMEOUT = 1024
) (
   input logic             clk,
   input logic             rst,
   conv_job_sched_if.slave bus
);

   localparam int          PTR_W   = $clog2(QDEPTH);
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_ENG,
      S_START,
      S_RUN,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
      logic [7:0]        id;
   } job_t;

   state_e           state_q, state_d;
   job_t             q_mem [QDEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       id_q;
   job_t             cur_q;
   logic             err_q, err_d;
   logic [15:0]      wd_q, wd_d;
   logic             push, pop, full, empty;

   assign full  = (count_q == CNT_W'(QDEPTH));
   assign empty = (count_q == '0);

   // No bypass: a full queue stays closed even in the cycle DONE frees a slot.
   assign bus.job_ready_o = rst & ~full;
   assign push            = bus.job_valid_i & bus.job_ready_o;
   assign pop             = (state_q == S_DONE);

   // NOTE: every sequential register uses <= so all of them update from the
   // same pre-edge values; a blocking = here would create ordering races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         id_q     <= '0;
         cur_q    <= '0;
         err_q    <= 1'b0;
         wd_q     <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            id_q     <= id_q + 8'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (state_q == S_RESET_ENG) begin
            cur_q <= q_mem[rd_ptr_q];
         end
      end
   end

   // NOTE: the queue storage has no reset; the pointers and count define which
   // entries are live, so clearing the array would only cost flops.
   always_ff @(posedge clk) begin
      if (push) begin
         q_mem[wr_ptr_q] <= '{src: bus.job_src_i, dst: bus.job_dst_i, id: id_q};
      end
   end

   // NOTE: each always_comb output gets its default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      wd_d    = wd_q;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_RESET_ENG;
            end
         end
         S_RESET_ENG: begin
            state_d = S_START;
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            wd_d = wd_q + 16'd1;
            // A ready engine wins over a watchdog expiring in the same cycle.
            if (bus.eng_ready_i) begin
               state_d = S_DONE;
               err_d   = 1'b0;
            end else if (wd_q == WD_LAST) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_DONE: begin
            state_d = (count_q > CNT_W'(1)) ? S_RESET_ENG : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.eng_rst_o    = (state_q == S_IDLE) || (state_q == S_RESET_ENG) ||
                             (state_q == S_DONE);
   assign bus.eng_start_o  = (state_q == S_START);
   assign bus.done_valid_o = (state_q == S_DONE);
   assign bus.done_id_o    = cur_q.id;
   assign bus.done_err_o   = (state_q == S_DONE) & err_q;
   assign bus.busy_o       = (state_q != S_IDLE);
   assign bus.pending_o    = count_q;

   // Relocation wraps modulo 2^ADDR_W by truncation.
   assign bus.mem_addr_rd_o = cur_q.src + bus.eng_addr_rd_i;
   assign bus.mem_addr_wr_o = cur_q.dst + bus.eng_addr_wr_i;

endmodule

// File: tb/tb_conv_job_sched.sv
// Directed bench for conv_job_sched with a small cycle-accurate engine model
// that raises ready a fixed number of cycles after start.
module tb_conv_job_sched;

   localparam int ADDR_W  = 17;
   localparam int QDEPTH  = 4;
   localparam int CNT_W   = 3;
   localparam int TIMEOUT = 16;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   conv_job_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   conv_job_sched #(
      .ADDR_W (ADDR_W),
      .QDEPTH (QDEPTH),
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: samples eng_rst/eng_start before each edge, updates just after it.
   int   run_len    = 3;
   bit   hold_ready = 1'b0;
   bit   addr_ovr   = 1'b0;
   int   eng_cnt    = 0;
   bit   eng_run    = 1'b0;
   logic cap_rst, cap_start;

   initial begin
      bus.eng_ready_i   = 1'b0;
      bus.eng_addr_rd_i = '0;
      bus.eng_addr_wr_i = '0;
      forever begin
         @(negedge clk);
         cap_rst   = bus.eng_rst_o;
         cap_start = bus.eng_start_o;
         @(posedge clk);
         #1;
         if (cap_rst === 1'b1) begin
            eng_run = 1'b0;
            eng_cnt = 0;
            bus.eng_ready_i = 1'b0;
         end else if (cap_start === 1'b1) begin
            eng_run = 1'b1;
            eng_cnt = 0;
         end else if (eng_run && !hold_ready && !bus.eng_ready_i) begin
            eng_cnt++;
            if (eng_cnt >= run_len) bus.eng_ready_i = 1'b1;
         end
         if (!addr_ovr) begin
            bus.eng_addr_rd_i = ADDR_W'(eng_cnt);
            bus.eng_addr_wr_i = ADDR_W'(eng_cnt);
         end
      end
   end

   // Per-job observations gathered by watch().
   int                rn   [8];
   int                dn   [8];
   logic [7:0]        did  [8];
   logic              derr [8];
   logic [ADDR_W-1:0] rsrc [8];
   logic [ADDR_W-1:0] rdst [8];

   task automatic watch(input int n, output bit ok);
      int k = 0;
      int budget = 400;
      bit prev_run = 1'b0;
      bit run_now;
      while (k < n && budget > 0) begin
         @(negedge clk);
         budget--;
         run_now = bus.busy_o && !bus.eng_rst_o && !bus.eng_start_o;
         if (run_now && !prev_run) begin
            rn[k]   = cyc;
            rsrc[k] = bus.mem_addr_rd_o;
            rdst[k] = bus.mem_addr_wr_o;
         end
         prev_run = run_now;
         if (bus.done_valid_o === 1'b1) begin
            dn[k]   = cyc;
            did[k]  = bus.done_id_o;
            derr[k] = bus.done_err_o;
            k++;
         end
      end
      ok = (k == n);
   endtask

   task automatic wait_run(output bit ok);
      int b = 0;
      ok = 1'b0;
      while (b < 100 && !ok) begin
         @(negedge clk);
         b++;
         if (bus.busy_o && !bus.eng_rst_o && !bus.eng_start_o) ok = 1'b1;
      end
   endtask

   task automatic push(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
      bus.job_valid_i = 1'b1;
      bus.job_src_i   = src;
      bus.job_dst_i   = dst;
      @(negedge clk);
      bus.job_valid_i = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.job_valid_i = 1'b0;
      hold_ready = 1'b0;
      addr_ovr   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.job_valid_i = 1'b1;
      bus.job_src_i   = 17'h00123;
      bus.job_dst_i   = 17'h00456;
      repeat (2) @(negedge clk);
      checks++; if (bus.eng_rst_o !== 1'b1)    begin errors++; $display("FAIL reset eng_rst: got %b want 1", bus.eng_rst_o); end
      checks++; if (bus.eng_start_o !== 1'b0)  begin errors++; $display("FAIL reset eng_start: got %b want 0", bus.eng_start_o); end
      checks++; if (bus.done_valid_o !== 1'b0) begin errors++; $display("FAIL reset done_valid: got %b want 0", bus.done_valid_o); end
      checks++; if (bus.done_id_o !== 8'd0)    begin errors++; $display("FAIL reset done_id: got %0d want 0", bus.done_id_o); end
      checks++; if (bus.done_err_o !== 1'b0)   begin errors++; $display("FAIL reset done_err: got %b want 0", bus.done_err_o); end
      checks++; if (bus.busy_o !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy_o); end
      checks++; if (bus.pending_o !== 3'd0)    begin errors++; $display("FAIL reset pending: got %0d want 0", bus.pending_o); end
      checks++; if (bus.job_ready_o !== 1'b0)  begin errors++; $display("FAIL reset job_ready: got %b want 0", bus.job_ready_o); end
      bus.job_valid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.job_ready_o !== 1'b1)  begin errors++; $display("FAIL post-reset job_ready: got %b want 1", bus.job_ready_o); end
      checks++; if (bus.pending_o !== 3'd0)    begin errors++; $display("FAIL post-reset pending (push during reset): got %0d want 0", bus.pending_o); end
   endtask

   task automatic test_single();
      push(17'h00000, 17'h00100);
      checks++; if (bus.pending_o !== 3'd1)   begin errors++; $display("FAIL single pending E0: got %0d want 1", bus.pending_o); end
      checks++; if (bus.busy_o !== 1'b0)      begin errors++; $display("FAIL single busy E0: got %b want 0", bus.busy_o); end
      @(negedge clk);
      checks++; if (bus.eng_rst_o !== 1'b1 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL single E1 eng_rst/busy: got %b/%b want 1/1", bus.eng_rst_o, bus.busy_o); end
      @(negedge clk);
      checks++; if (bus.eng_start_o !== 1'b1) begin errors++; $display("FAIL single E2 eng_start: got %b want 1", bus.eng_start_o); end
      @(negedge clk);
      checks++; if (bus.eng_rst_o !== 1'b0 || bus.eng_start_o !== 1'b0) begin errors++; $display("FAIL single E3 run: got rst %b start %b want 0 0", bus.eng_rst_o, bus.eng_start_o); end
      checks++; if (bus.mem_addr_wr_o !== 17'h00100) begin errors++; $display("FAIL single mem_addr_wr E3: got %h want 00100", bus.mem_addr_wr_o); end
      @(negedge clk);
      checks++; if (bus.mem_addr_wr_o !== 17'h00101) begin errors++; $display("FAIL single mem_addr_wr E4: got %h want 00101", bus.mem_addr_wr_o); end
      checks++; if (bus.mem_addr_rd_o !== 17'h00001) begin errors++; $display("FAIL single mem_addr_rd E4: got %h want 00001", bus.mem_addr_rd_o); end
      repeat (2) @(negedge clk);
      checks++; if (bus.done_valid_o !== 1'b0) begin errors++; $display("FAIL single early done: got %b want 0", bus.done_valid_o); end
      @(negedge clk);
      checks++; if (bus.done_valid_o !== 1'b1 || bus.done_id_o !== 8'd0 || bus.done_err_o !== 1'b0) begin
         errors++; $display("FAIL single done: got v%b id%0d e%b want v1 id0 e0", bus.done_valid_o, bus.done_id_o, bus.done_err_o);
      end
      @(negedge clk);
      checks++; if (bus.done_valid_o !== 1'b0) begin errors++; $display("FAIL single done width: got %b want 0", bus.done_valid_o); end
      checks++; if (bus.busy_o !== 1'b0 || bus.pending_o !== 3'd0) begin errors++; $display("FAIL single idle: got busy %b pending %0d want 0 0", bus.busy_o, bus.pending_o); end
   endtask

   task automatic test_back_to_back();
      int acc [5];
      bit ok;
      apply_reset();
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               int bud = 0;
               bus.job_valid_i = 1'b1;
               bus.job_src_i   = ADDR_W'(i * 'h1000);
               bus.job_dst_i   = ADDR_W'('h10000 + i * 'h100);
               while (bus.job_ready_o !== 1'b1 && bud < 100) begin
                  @(negedge clk);
                  bud++;
               end
               acc[i] = cyc;
               @(negedge clk);
               if (i == 3) begin
                  checks++; if (bus.job_ready_o !== 1'b0) begin errors++; $display("FAIL b2b job_ready after 4th: got %b want 0", bus.job_ready_o); end
                  checks++; if (bus.pending_o !== 3'd4)   begin errors++; $display("FAIL b2b pending full: got %0d want 4", bus.pending_o); end
               end
            end
            bus.job_valid_i = 1'b0;
         end
         watch(5, ok);
      join
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b timeout: got %b dones want all 5", ok); end
      checks++; if (acc[4] - acc[0] !== 9) begin errors++; $display("FAIL b2b 5th accept offset: got %0d want 9", acc[4] - acc[0]); end
      checks++; if (!(dn[0] < acc[4])) begin errors++; $display("FAIL b2b 5th before first done: got done %0d accept %0d", dn[0], acc[4]); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (did[i] !== 8'(i)) begin errors++; $display("FAIL b2b id[%0d]: got %0d want %0d", i, did[i], i); end
         checks++; if (derr[i] !== 1'b0) begin errors++; $display("FAIL b2b err[%0d]: got %b want 0", i, derr[i]); end
         checks++; if (rsrc[i] !== ADDR_W'(i * 'h1000)) begin errors++; $display("FAIL b2b src[%0d]: got %h want %h", i, rsrc[i], ADDR_W'(i * 'h1000)); end
         checks++; if (rdst[i] !== ADDR_W'('h10000 + i * 'h100)) begin errors++; $display("FAIL b2b dst[%0d]: got %h want %h", i, rdst[i], ADDR_W'('h10000 + i * 'h100)); end
         checks++; if (dn[i] - rn[i] !== 4) begin errors++; $display("FAIL b2b run length[%0d]: got %0d want 4", i, dn[i] - rn[i]); end
         if (i < 4) begin
            checks++; if (rn[i+1] - dn[i] !== 3) begin errors++; $display("FAIL b2b gap[%0d]: got %0d want 3", i, rn[i+1] - dn[i]); end
         end
      end
      @(negedge clk);
      checks++; if (bus.busy_o !== 1'b0 || bus.pending_o !== 3'd0) begin errors++; $display("FAIL b2b drain: got busy %b pending %0d want 0 0", bus.busy_o, bus.pending_o); end
   endtask

   task automatic test_timeout();
      bit ok;
      int run_a, done_a;
      apply_reset();
      hold_ready = 1'b1;
      push(17'h00200, 17'h00300);
      push(17'h00400, 17'h00500);
      watch(1, ok);
      run_a  = rn[0];
      done_a = dn[0];
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout first done missing: got %b want 1", ok); end
      checks++; if (done_a - run_a !== TIMEOUT) begin errors++; $display("FAIL timeout latency: got %0d want %0d", done_a - run_a, TIMEOUT); end
      checks++; if (did[0] !== 8'd0 || derr[0] !== 1'b1) begin errors++; $display("FAIL timeout first: got id%0d e%b want id0 e1", did[0], derr[0]); end
      hold_ready = 1'b0;
      watch(1, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout second done missing: got %b want 1", ok); end
      checks++; if (did[0] !== 8'd1 || derr[0] !== 1'b0) begin errors++; $display("FAIL timeout second: got id%0d e%b want id1 e0", did[0], derr[0]); end
      checks++; if (dn[0] - rn[0] !== 4) begin errors++; $display("FAIL timeout second run length: got %0d want 4", dn[0] - rn[0]); end
      checks++; if (rsrc[0] !== 17'h00400) begin errors++; $display("FAIL timeout second src: got %h want 00400", rsrc[0]); end
   endtask

   task automatic test_wrap();
      bit ok;
      apply_reset();
      addr_ovr = 1'b1;
      bus.eng_addr_rd_i = 17'd3;
      bus.eng_addr_wr_i = 17'd5;
      push(17'h1FFFE, 17'h1FFFD);
      wait_run(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap no RUN: got %b want 1", ok); end
      checks++; if (bus.mem_addr_rd_o !== 17'h00001) begin errors++; $display("FAIL wrap rd: got %h want 00001", bus.mem_addr_rd_o); end
      checks++; if (bus.mem_addr_wr_o !== 17'h00002) begin errors++; $display("FAIL wrap wr: got %h want 00002", bus.mem_addr_wr_o); end
      bus.eng_addr_rd_i = 17'h1FFFF;
      #1;
      checks++; if (bus.mem_addr_rd_o !== 17'h1FFFD) begin errors++; $display("FAIL wrap rd max: got %h want 1fffd", bus.mem_addr_rd_o); end
      watch(1, ok);
      checks++; if (ok !== 1'b1 || derr[0] !== 1'b0) begin errors++; $display("FAIL wrap done: got ok %b err %b want 1 0", ok, derr[0]); end
      addr_ovr = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      apply_reset();
      push(17'h00010, 17'h00020);
      push(17'h00030, 17'h00040);
      push(17'h00050, 17'h00060);
      wait_run(ok);
      @(negedge clk);
      checks++; if (ok !== 1'b1 || bus.pending_o !== 3'd3) begin errors++; $display("FAIL midrst setup: got run %b pending %0d want 1 3", ok, bus.pending_o); end
      rst = 1'b0;
      #1;
      checks++; if (bus.eng_rst_o !== 1'b1 || bus.eng_start_o !== 1'b0) begin errors++; $display("FAIL midrst eng: got rst %b start %b want 1 0", bus.eng_rst_o, bus.eng_start_o); end
      checks++; if (bus.busy_o !== 1'b0 || bus.pending_o !== 3'd0 || bus.job_ready_o !== 1'b0) begin
         errors++; $display("FAIL midrst status: got busy %b pending %0d ready %b want 0 0 0", bus.busy_o, bus.pending_o, bus.job_ready_o);
      end
      checks++; if (bus.done_valid_o !== 1'b0 || bus.done_id_o !== 8'd0 || bus.done_err_o !== 1'b0) begin
         errors++; $display("FAIL midrst done: got v%b id%0d e%b want 0 0 0", bus.done_valid_o, bus.done_id_o, bus.done_err_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.done_valid_o !== 1'b0) begin errors++; $display("FAIL midrst spurious done %0d: got %b want 0", i, bus.done_valid_o); end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.pending_o !== 3'd0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL midrst release: got pending %0d busy %b want 0 0", bus.pending_o, bus.busy_o); end
      push(17'h00070, 17'h00080);
      watch(1, ok);
      checks++; if (ok !== 1'b1 || did[0] !== 8'd0 || derr[0] !== 1'b0) begin
         errors++; $display("FAIL midrst new job: got ok %b id%0d e%b want 1 id0 e0", ok, did[0], derr[0]);
      end
   endtask

   task automatic test_push_on_done();
      bit ok;
      int b = 0;
      apply_reset();
      push(17'h00100, 17'h00200);
      push(17'h00300, 17'h00400);
      while (bus.done_valid_o !== 1'b1 && b < 100) begin
         @(negedge clk);
         b++;
      end
      checks++; if (bus.done_valid_o !== 1'b1 || bus.pending_o !== 3'd2) begin
         errors++; $display("FAIL pushdone setup: got done %b pending %0d want 1 2", bus.done_valid_o, bus.pending_o);
      end
      push(17'h00500, 17'h00600);
      checks++; if (bus.pending_o !== 3'd2) begin errors++; $display("FAIL pushdone pending: got %0d want 2", bus.pending_o); end
      checks++; if (bus.done_valid_o !== 1'b0) begin errors++; $display("FAIL pushdone pulse width: got %b want 0", bus.done_valid_o); end
      watch(2, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pushdone remaining dones: got %b want 1", ok); end
      checks++; if (did[0] !== 8'd1 || did[1] !== 8'd2) begin errors++; $display("FAIL pushdone ids: got %0d,%0d want 1,2", did[0], did[1]); end
      checks++; if (rsrc[1] !== 17'h00500) begin errors++; $display("FAIL pushdone src of pushed job: got %h want 00500", rsrc[1]); end
      @(negedge clk);
      checks++; if (bus.pending_o !== 3'd0) begin errors++; $display("FAIL pushdone drain: got %0d want 0", bus.pending_o); end
   endtask

   initial begin
      rst = 1'b0;
      bus.job_valid_i = 1'b0;
      bus.job_src_i   = '0;
      bus.job_dst_i   = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_wrap();
      test_reset_mid();
      test_push_on_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
